uart_rxfifo: RTL

UART_RXFIFO -- requirements
Module: uart_rxfifo

---
 rtl/uart_rxfifo_if.sv | 29 ++
 rtl/uart_rxfifo.sv | 118 +++++++++++
 2 files changed

// File: rtl/uart_rxfifo_if.sv
// Receiver-side strobe/flags plus Wishbone slave signals for the UART RX FIFO.
// The slave modport is used by the FIFO, the master modport by whoever drives it.
interface uart_rxfifo_if;
    logic        i_rx_stb;
    logic [7:0]  i_rx_data;
    logic        i_rx_break;
    logic        i_rx_ferr;
    logic        i_rx_perr;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic        i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    modport slave (
        input  i_rx_stb, i_rx_data, i_rx_break, i_rx_ferr, i_rx_perr,
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data
    );

    modport master (
        output i_rx_stb, i_rx_data, i_rx_break, i_rx_ferr, i_rx_perr,
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data
    );
endinterface

// File: rtl/uart_rxfifo.sv
// UART receive FIFO with Wishbone DATA/STATUS registers; ack and read data one cycle after stb,
// never stalls; bytes arriving while full are dropped and latch a sticky overflow flag.
module uart_rxfifo #(
    parameter int LGFLEN = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    uart_rxfifo_if.slave     bus,
    output logic             o_rx_int,
    output logic             o_rx_half,
    output logic             o_rts
);
    localparam int DEPTH = 1 << LGFLEN;
    localparam logic [LGFLEN:0] FULL_CNT = (LGFLEN+1)'(DEPTH);
    localparam logic [LGFLEN:0] HALF_CNT = (LGFLEN+1)'(DEPTH / 2);
    localparam logic [LGFLEN:0] RTS_CNT  = (LGFLEN+1)'(DEPTH - 2);

    logic [10:0]       mem_q [DEPTH];
    logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGFLEN:0]   fill_q, fill_d;
    logic              ovf_q, ovf_d;
    logic              ack_q;
    logic [31:0]       rdata_q, rdata_d;

    logic        empty, full, half;
    logic        pop_req, do_pop, do_push;
    logic        wr_status, flush, ovf_clr, ovf_set;
    logic [10:0] head, entry;
    logic        unused_ok;

    assign empty = (fill_q == '0);
    assign full  = (fill_q == FULL_CNT);
    assign half  = (fill_q >= HALF_CNT);
    assign head  = mem_q[rd_ptr_q];
    assign entry = {bus.i_rx_break, bus.i_rx_ferr, bus.i_rx_perr, bus.i_rx_data};

    assign pop_req   = bus.i_wb_stb && !bus.i_wb_we && !bus.i_wb_addr;
    assign do_pop    = pop_req && !empty;
    assign wr_status = bus.i_wb_stb && bus.i_wb_we && bus.i_wb_addr;
    assign flush     = wr_status && bus.i_wb_data[30];
    assign ovf_clr   = wr_status && bus.i_wb_data[31];

    // A pop on a full FIFO frees the slot the incoming byte needs; a flush discards it silently.
    assign do_push = bus.i_rx_stb && (!full || do_pop) && !flush;
    assign ovf_set = bus.i_rx_stb && full && !do_pop && !flush;

    always_comb begin
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            fill_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill_d = fill_q + 1'b1;
                2'b01:   fill_d = fill_q - 1'b1;
                default: fill_d = fill_q;
            endcase
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (bus.i_wb_stb) begin
            if (!bus.i_wb_addr) begin
                if (empty) rdata_d = 32'h0000_0100;
                else       rdata_d = {20'h0, head[10:8], 1'b0, head[7:0]};
            end else begin
                rdata_d = {ovf_q, full, half, empty, 12'h0,
                           {(15-LGFLEN){1'b0}}, fill_q};
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
            ack_q    <= bus.i_wb_stb;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= entry;
    end

    assign bus.o_wb_ack   = ack_q;
    assign bus.o_wb_stall = 1'b0;
    assign bus.o_wb_data  = rdata_q;

    assign o_rx_int  = !empty;
    assign o_rx_half = half;
    assign o_rts     = (fill_q < RTS_CNT);

    // Cycle qualifier and the low write-data bits carry no meaning for this block.
    assign unused_ok = ^{bus.i_wb_cyc, bus.i_wb_data[29:0]};
endmodule
